// File: rtl/trap_redirect_ctrl_if.sv
// Redirect/CSR bus between the pipeline (master) and the trap redirect controller (slave).
// No handshake backpressure exists: inputs are sampled on every clock edge where stall=0, and
// pc_redirect/flush form a one-cycle strobe that fetch must act on in the cycle it is high.
interface trap_redirect_ctrl_if #(parameter int XLEN = 32);
  logic            ext_irq;
  logic            timer_irq;
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_mret;
  logic            ex_wfi;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            sleep;
  logic [1:0]      state_dbg;

  modport master (
    output ext_irq, timer_irq, stall, ex_valid, ex_pc, ex_mret, ex_wfi, ex_taken, ex_target,
           csr_we, csr_addr, csr_wdata,
    input  csr_rdata, pc_redirect, redirect_pc, flush, sleep, state_dbg
  );

  modport slave (
    input  ext_irq, timer_irq, stall, ex_valid, ex_pc, ex_mret, ex_wfi, ex_taken, ex_target,
           csr_we, csr_addr, csr_wdata,
    output csr_rdata, pc_redirect, redirect_pc, flush, sleep, state_dbg
  );
endinterface

// File: rtl/trap_redirect_ctrl.sv
// Trap/redirect sequencer beside EX: interrupt entry, mret, WFI sleep and branch redirects,
// arbitrated interrupt > mret > branch, plus the machine CSRs it owns.
module trap_redirect_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h0001_0000
) (
  input logic                 clk,
  input logic                 rst,
  trap_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_ENTER = 2'd1, ST_SLEEP = 2'd2} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state, state_nxt;
  logic            mstatus_mie, mstatus_mpie, mie_ext, mie_tmr;
  logic [XLEN-1:0] mtvec, mepc, mcause, wfi_pc;
  logic            redirect_q, sleep_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            pend_ext, pend_tmr, pend, take;
  logic            run_dec, trap_run, trap_sleep, wake_run, mret_now, br_now, sleep_enter;
  logic            csr_wr, trap_now, redir_now;
  logic [XLEN-1:0] redir_target, trap_epc, wfi_next;

  assign pend_ext = bus.ext_irq & mie_ext;
  assign pend_tmr = bus.timer_irq & mie_tmr;
  assign pend     = pend_ext | pend_tmr;
  assign take     = pend & mstatus_mie;
  assign wfi_next = wfi_pc + XLEN'(4);

  // Decode this cycle's decision; nothing is decided while stalled
  always_comb begin
    run_dec     = (state == ST_RUN) & bus.ex_valid & ~bus.stall;
    trap_run    = run_dec & take;
    mret_now    = run_dec & ~take & bus.ex_mret;
    br_now      = run_dec & ~take & ~bus.ex_mret & bus.ex_taken;
    sleep_enter = run_dec & ~take & ~bus.ex_mret & ~bus.ex_taken & bus.ex_wfi & ~pend;
    csr_wr      = run_dec & ~take & bus.csr_we;
    trap_sleep  = (state == ST_SLEEP) & ~bus.stall & pend & mstatus_mie;
    wake_run    = (state == ST_SLEEP) & ~bus.stall & pend & ~mstatus_mie;
    trap_now    = trap_run | trap_sleep;
    redir_now   = trap_now | mret_now | br_now | wake_run;
    trap_epc    = (trap_sleep ? wfi_next : bus.ex_pc) & ALIGN_MASK;
    if (trap_now)      redir_target = mtvec & ALIGN_MASK;
    else if (mret_now) redir_target = mepc;
    else if (br_now)   redir_target = bus.ex_target;
    else               redir_target = wfi_next;
  end

  // Next FSM state; ENTER lasts one unstalled cycle while the trap redirect is presented
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (trap_run) state_nxt = ST_ENTER;
                else if (sleep_enter) state_nxt = ST_SLEEP;
      ST_ENTER: if (!bus.stall) state_nxt = ST_RUN;
      ST_SLEEP: if (trap_sleep) state_nxt = ST_ENTER;
                else if (wake_run) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Registered redirect outputs and CSR updates; mret is applied after a CSR write so it wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      sleep_q       <= 1'b0;
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mie_ext       <= 1'b0;
      mie_tmr       <= 1'b0;
      mtvec         <= MTVEC_RST;
      mepc          <= '0;
      mcause        <= '0;
      wfi_pc        <= '0;
    end else begin
      redirect_q <= redir_now;
      sleep_q    <= (state_nxt == ST_SLEEP);
      if (redir_now)   redirect_pc_q <= redir_target;
      if (sleep_enter) wfi_pc        <= bus.ex_pc;
      if (csr_wr) begin
        case (bus.csr_addr)
          12'h300: begin
            mstatus_mie  <= bus.csr_wdata[3];
            mstatus_mpie <= bus.csr_wdata[7];
          end
          12'h304: begin
            mie_ext <= bus.csr_wdata[11];
            mie_tmr <= bus.csr_wdata[7];
          end
          12'h305: mtvec <= bus.csr_wdata;
          12'h341: mepc  <= bus.csr_wdata & ALIGN_MASK;
          default: ;
        endcase
      end
      if (trap_now) begin
        mepc         <= trap_epc;
        mcause       <= {1'b1, {(XLEN-5){1'b0}}, (pend_ext ? 4'd11 : 4'd7)};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end
      if (mret_now) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  // Combinational CSR read port
  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = {{(XLEN-8){1'b0}}, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      12'h304: bus.csr_rdata = {{(XLEN-12){1'b0}}, mie_ext, 3'b000, mie_tmr, 7'b0000000};
      12'h305: bus.csr_rdata = mtvec;
      12'h341: bus.csr_rdata = mepc;
      12'h342: bus.csr_rdata = mcause;
      12'h344: bus.csr_rdata = {{(XLEN-12){1'b0}}, bus.ext_irq, 3'b000, bus.timer_irq, 7'b0000000};
      default: bus.csr_rdata = '0;
    endcase
  end

  assign bus.pc_redirect = redirect_q;
  assign bus.flush       = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.sleep       = sleep_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// Bench for trap_redirect_ctrl: directed scenarios then random traffic, checked against an
// architectural model; redirects go through an expected queue drained by a separate monitor.
module tb_trap_redirect_ctrl;
  localparam int          XLEN      = 32;
  localparam logic [31:0] MTVEC_RST = 32'h0001_0000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trap_redirect_ctrl_if #(.XLEN(XLEN)) bus();
  trap_redirect_ctrl #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) dut (.clk(clk), .rst(rst), .bus(bus));

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [XLEN-1:0] exp_q[$];   // expected redirect targets, in order
  logic [2:0]      ctl_q[$];   // per-cycle expected {pc_redirect, flush, sleep}
  logic [2:0]      mon_e;

  // Architectural model state
  bit          m_known = 0;
  bit          m_asleep, m_entering, m_mie, m_mpie, m_ie11, m_ie7;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_wfi_pc;
  int          sleep_run = 0;
  logic [11:0] addr_tab[7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return (32'(m_ie11) << 11) | (32'(m_ie7) << 7);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (32'(bus.ext_irq) << 11) | (32'(bus.timer_irq) << 7);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_known = 1; m_asleep = 0; m_entering = 0; m_mie = 0; m_mpie = 0; m_ie11 = 0; m_ie7 = 0;
    m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0; m_wfi_pc = 0;
  endtask

  task automatic model_trap(input logic [31:0] epc, input bit ext_first);
    exp_q.push_back(m_mtvec & 32'hFFFF_FFFC);
    m_mepc     = epc & 32'hFFFF_FFFC;
    m_mcause   = ext_first ? 32'h8000_000B : 32'h8000_0007;
    m_mpie     = m_mie;
    m_mie      = 0;
    m_entering = 1;
  endtask

  // Driver: inputs are already set just after a negedge; check the read port, advance the model
  task automatic tick();
    bit pulse, pe, pt;
    logic [31:0] old_mepc;
    bit old_mpie;
    logic [31:0] wd;
    #1;
    if (m_known) check("csr_rdata", bus.csr_rdata, model_read(bus.csr_addr));
    pulse = 0;
    if (!rst) model_reset();
    else if (!bus.stall) begin
      pe = bus.ext_irq && m_ie11;
      pt = bus.timer_irq && m_ie7;
      if (m_entering) m_entering = 0;
      else if (m_asleep) begin
        if (pe || pt) begin
          m_asleep = 0;
          pulse = 1;
          if (m_mie) model_trap(m_wfi_pc + 32'd4, pe);
          else exp_q.push_back(m_wfi_pc + 32'd4);
        end
      end else if (bus.ex_valid) begin
        if ((pe || pt) && m_mie) begin
          pulse = 1;
          model_trap(bus.ex_pc, pe);
        end else begin
          old_mepc = m_mepc;
          old_mpie = m_mpie;
          wd = bus.csr_wdata;
          if (bus.csr_we) begin
            case (bus.csr_addr)
              12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
              12'h304: begin m_ie11 = wd[11]; m_ie7 = wd[7]; end
              12'h305: m_mtvec = wd;
              12'h341: m_mepc = wd & 32'hFFFF_FFFC;
              default: ;
            endcase
          end
          if (bus.ex_mret) begin
            pulse = 1;
            exp_q.push_back(old_mepc);
            m_mie  = old_mpie;
            m_mpie = 1;
          end else if (bus.ex_taken) begin
            pulse = 1;
            exp_q.push_back(bus.ex_target);
          end else if (bus.ex_wfi && !(pe || pt)) begin
            m_asleep = 1;
            m_wfi_pc = bus.ex_pc;
          end
        end
      end
    end
    ctl_q.push_back({pulse, pulse, m_asleep});
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ext_irq = 0; bus.timer_irq = 0; bus.stall = 0; bus.ex_valid = 0; bus.ex_pc = 0;
    bus.ex_mret = 0; bus.ex_wfi = 0; bus.ex_taken = 0; bus.ex_target = 0;
    bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    idle();
    bus.ex_valid = 1; bus.csr_we = 1; bus.csr_addr = a; bus.csr_wdata = d;
    tick();
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    check(name, bus.csr_rdata, exp);
  endtask

  // Monitor: compares strobes/sleep every cycle and pops a target whenever a redirect appears
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ctl_q.size() != 0) begin
        mon_e = ctl_q.pop_front();
        check("ctl{redir,flush,sleep}", {29'b0, bus.pc_redirect, bus.flush, bus.sleep}, {29'b0, mon_e});
        if (bus.pc_redirect === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL redirect_unexpected: got pc %h expected no redirect", bus.redirect_pc);
          end else check("redirect_pc", bus.redirect_pc, exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus
  initial begin
    idle();
    @(negedge clk);
    rst = 0; tick(); tick(); rst = 1;
    peek("rst_mtvec", 12'h305, MTVEC_RST);
    peek("rst_mstatus", 12'h300, 32'h0);
    peek("rst_mcause", 12'h342, 32'h0);
    peek("rst_mepc", 12'h341, 32'h0);

    // external interrupt entry
    csr_write(12'h304, 32'h880);
    csr_write(12'h300, 32'h8);
    idle(); bus.ext_irq = 1; bus.ex_valid = 1; bus.ex_pc = 32'h100; tick();
    idle(); tick();
    peek("t1_mepc", 12'h341, 32'h100);
    peek("t1_mcause", 12'h342, 32'h8000_000B);
    peek("t1_mstatus", 12'h300, 32'h80);

    // ext beats timer, mret, then timer taken
    csr_write(12'h300, 32'h8);
    idle(); bus.ext_irq = 1; bus.timer_irq = 1; bus.ex_valid = 1; bus.ex_pc = 32'h100; tick();
    peek("t2_mcause_ext", 12'h342, 32'h8000_000B);
    idle(); bus.timer_irq = 1; tick();
    idle(); bus.timer_irq = 1; bus.ex_valid = 1; bus.ex_mret = 1; tick();
    idle(); bus.timer_irq = 1; bus.ex_valid = 1; bus.ex_pc = 32'h100; tick();
    idle(); tick();
    peek("t2_mcause_tmr", 12'h342, 32'h8000_0007);

    // mret to a written mepc
    csr_write(12'h341, 32'h200);
    csr_write(12'h300, 32'h80);
    idle(); bus.ex_valid = 1; bus.ex_mret = 1; tick();
    idle(); tick();
    peek("t3_mstatus", 12'h300, 32'h88);

    // WFI sleep with MIE=0, timer wakes after 5 cycles
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h80);
    idle(); bus.ex_valid = 1; bus.ex_wfi = 1; bus.ex_pc = 32'h300; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); bus.ex_valid = 1; bus.ex_taken = 1; bus.ex_target = 32'h999C; tick();
    end
    idle(); bus.timer_irq = 1; tick();
    idle(); tick();
    peek("t4_mcause_kept", 12'h342, 32'h8000_0007);

    // branch + interrupt together, decision delayed by stall
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    idle(); bus.ex_valid = 1; bus.ex_taken = 1; bus.ex_target = 32'h400; bus.ex_pc = 32'h500;
    bus.ext_irq = 1; bus.stall = 1; tick(); tick();
    bus.stall = 0; tick();
    idle(); tick();
    peek("t5_mepc", 12'h341, 32'h500);

    // reset while in ENTER
    csr_write(12'h305, 32'h2000);
    csr_write(12'h300, 32'h8);
    idle(); bus.ext_irq = 1; bus.ex_valid = 1; bus.ex_pc = 32'h600; tick();
    idle(); rst = 0; tick(); rst = 1;
    idle(); tick();
    peek("t6_mtvec", 12'h305, MTVEC_RST);
    peek("t6_mepc", 12'h341, 32'h0);

    // wake address wraps past the top of memory
    csr_write(12'h304, 32'h80);
    idle(); bus.ex_valid = 1; bus.ex_wfi = 1; bus.ex_pc = 32'hFFFF_FFFC; tick();
    idle(); tick();
    idle(); bus.timer_irq = 1; tick();
    idle(); tick();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if (m_asleep) sleep_run++; else sleep_run = 0;
      idle();
      rst = (sleep_run > 12) ? 1'b0 : 1'b1;
      bus.ext_irq   = ($urandom_range(15) == 0);
      bus.timer_irq = ($urandom_range(15) == 0);
      bus.stall     = ($urandom_range(5) == 0);
      bus.ex_valid  = ($urandom_range(3) != 0);
      bus.ex_pc     = $urandom() & 32'hFFFF_FFFC;
      bus.ex_mret   = ($urandom_range(9) == 0);
      bus.ex_wfi    = ($urandom_range(11) == 0);
      bus.ex_taken  = ($urandom_range(3) == 0);
      bus.ex_target = $urandom() & 32'hFFFF_FFFC;
      bus.csr_we    = ($urandom_range(4) == 0);
      bus.csr_addr  = addr_tab[$urandom_range(6)];
      bus.csr_wdata = $urandom();
      tick();
    end
    rst = 1;
    idle(); tick(); tick(); tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
